mc_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS core.
- Sequences fetch, decode, execute, memory and writeback across several cycles, driven by the opcode and funct fields split from the instruction register.
- Drives all datapath enables and mux selects.
- Talks to a shared instruction/data memory through a req/ready handshake.

---
 rtl/mc_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS core.
// Sequences fetch/decode/execute/memory/writeback, drives all datapath
// enables and mux selects, and runs the req/ready handshake to the shared
// instruction/data memory with a bounded wait.
module mc_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       illegal,
   output logic       mem_err,
   output logic       retire,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXE_R  = 4'd2,
      S_EXE_I  = 4'd3,
      S_WB_ALU = 4'd4,
      S_WB_LUI = 4'd5,
      S_ADDR   = 4'd6,
      S_MEM_RD = 4'd7,
      S_WB_MEM = 4'd8,
      S_MEM_WR = 4'd9,
      S_BEQ    = 4'd10,
      S_JUMP   = 4'd11,
      S_JR     = 4'd12
   } state_t;

   typedef enum logic [3:0] {
      C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
   } cls_t;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [7:0] TO_CNT  = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   cls_t       cls;
   logic       in_mem;
   logic       expire;

   logic       pc_write_s, ir_write_s, reg_write_s;
   logic [1:0] reg_dst_s, wd_sel_s, alu_src_b_s, alu_op_s, pc_src_s;
   logic       mem_req_s, mem_we_s, mem_addr_sel_s;
   logic       illegal_s, mem_err_s, retire_s;

   // Instruction class from the IR opcode/funct fields.
   always_comb begin
      cls = C_ILL;
      unique case (opcode)
         6'b000000: begin
            unique case (funct)
               6'b100001: cls = C_ADDU;
               6'b100011: cls = C_SUBU;
               6'b001000: cls = C_JR;
               default:   cls = C_ILL;
            endcase
         end
         6'b001101: cls = C_ORI;
         6'b001111: cls = C_LUI;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100: cls = C_BEQ;
         6'b000010: cls = C_J;
         6'b000011: cls = C_JAL;
         default:   cls = C_ILL;
      endcase
   end

   assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   // Expiry is judged on the cycle after TIMEOUT wait cycles; a ready in that
   // same cycle still completes the access.
   assign expire = (cnt_q == TO_CNT);

   // Wait counter: counts unanswered request cycles, clears whenever an
   // access ends (ready or expiry) and outside memory states.
   always_comb begin
      cnt_d = '0;
      if (in_mem && !mem_ready && !expire) cnt_d = cnt_q + 8'd1;
   end

   // State and wait-counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            unique case (cls)
               C_ADDU, C_SUBU: state_d = S_EXE_R;
               C_ORI:          state_d = S_EXE_I;
               C_LUI:          state_d = S_WB_LUI;
               C_LW, C_SW:     state_d = S_ADDR;
               C_BEQ:          state_d = S_BEQ;
               C_J, C_JAL:     state_d = S_JUMP;
               C_JR:           state_d = S_JR;
               default:        state_d = S_FETCH;
            endcase
         end
         S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
         S_ADDR:   state_d = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (mem_ready)   state_d = S_WB_MEM;
            else if (expire) state_d = S_FETCH;
         end
         S_MEM_WR: begin
            if (mem_ready || expire) state_d = S_FETCH;
         end
         default:  state_d = S_FETCH;
      endcase
   end

   // Output decode from state plus IR fields and handshake inputs.
   always_comb begin
      pc_write_s     = 1'b0;
      ir_write_s     = 1'b0;
      reg_write_s    = 1'b0;
      reg_dst_s      = '0;
      wd_sel_s       = '0;
      alu_src_b_s    = '0;
      alu_op_s       = ALU_ADD;
      pc_src_s       = '0;
      mem_req_s      = 1'b0;
      mem_we_s       = 1'b0;
      mem_addr_sel_s = 1'b0;
      illegal_s      = 1'b0;
      mem_err_s      = 1'b0;
      retire_s       = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_req_s = 1'b1;
            if (mem_ready) begin
               ir_write_s = 1'b1;
               pc_write_s = 1'b1;
            end else if (expire) begin
               mem_err_s = 1'b1;
            end
         end
         S_DECODE: illegal_s = (cls == C_ILL);
         S_EXE_R:  alu_op_s = (cls == C_SUBU) ? ALU_SUB : ALU_ADD;
         S_EXE_I: begin
            alu_src_b_s = 2'd1;
            alu_op_s    = ALU_OR;
         end
         S_WB_ALU: begin
            reg_write_s = 1'b1;
            retire_s    = 1'b1;
            if (cls == C_ORI) begin
               alu_src_b_s = 2'd1;
               alu_op_s    = ALU_OR;
            end else begin
               reg_dst_s = 2'd1;
               alu_op_s  = (cls == C_SUBU) ? ALU_SUB : ALU_ADD;
            end
         end
         S_WB_LUI: begin
            reg_write_s = 1'b1;
            wd_sel_s    = 2'd3;
            retire_s    = 1'b1;
         end
         S_ADDR: alu_src_b_s = 2'd2;
         S_MEM_RD: begin
            mem_req_s      = 1'b1;
            mem_addr_sel_s = 1'b1;
            alu_src_b_s    = 2'd2;
            mem_err_s      = !mem_ready && expire;
         end
         S_WB_MEM: begin
            reg_write_s = 1'b1;
            wd_sel_s    = 2'd1;
            retire_s    = 1'b1;
         end
         S_MEM_WR: begin
            mem_req_s      = 1'b1;
            mem_we_s       = 1'b1;
            mem_addr_sel_s = 1'b1;
            alu_src_b_s    = 2'd2;
            retire_s       = mem_ready;
            mem_err_s      = !mem_ready && expire;
         end
         S_BEQ: begin
            alu_op_s   = ALU_SUB;
            pc_src_s   = 2'd1;
            pc_write_s = zero;
            retire_s   = 1'b1;
         end
         S_JUMP: begin
            pc_write_s = 1'b1;
            pc_src_s   = 2'd2;
            retire_s   = 1'b1;
            if (cls == C_JAL) begin
               reg_write_s = 1'b1;
               reg_dst_s   = 2'd2;
               wd_sel_s    = 2'd2;
            end
         end
         S_JR: begin
            pc_write_s = 1'b1;
            pc_src_s   = 2'd3;
            retire_s   = 1'b1;
         end
         default: ;
      endcase
   end

   // Outputs are gated by reset itself so nothing, not even mem_req, leaks
   // while reset is held low.
   assign pc_write     = reset & pc_write_s;
   assign ir_write     = reset & ir_write_s;
   assign reg_write    = reset & reg_write_s;
   assign reg_dst      = reset ? reg_dst_s   : '0;
   assign wd_sel       = reset ? wd_sel_s    : '0;
   assign alu_src_b    = reset ? alu_src_b_s : '0;
   assign alu_op       = reset ? alu_op_s    : '0;
   assign pc_src       = reset ? pc_src_s    : '0;
   assign mem_req      = reset & mem_req_s;
   assign mem_we       = reset & mem_we_s;
   assign mem_addr_sel = reset & mem_addr_sel_s;
   assign illegal      = reset & illegal_s;
   assign mem_err      = reset & mem_err_s;
   assign retire       = reset & retire_s;
   assign state_o      = reset ? state_q : '0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized bench for mc_ctrl. A per-instruction trace model
// builds the expected output vector of every cycle from the instruction
// class and the memory latency the bench chooses, then replays it.
module tb_mc_ctrl;

   localparam int unsigned T = 4;

   logic       clk, reset;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       pc_write, ir_write, reg_write;
   logic [1:0] reg_dst, wd_sel, alu_src_b, alu_op, pc_src;
   logic       mem_req, mem_we, mem_addr_sel, illegal, mem_err, retire;
   logic [3:0] state_o;

   mc_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .wd_sel(wd_sel),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .illegal(illegal), .mem_err(mem_err), .retire(retire), .state_o(state_o)
   );

   typedef struct packed {
      logic       pc_write, ir_write, reg_write;
      logic [1:0] reg_dst, wd_sel, alu_src_b, alu_op, pc_src;
      logic       mem_req, mem_we, mem_addr_sel, illegal, mem_err, retire;
   } outv_t;

   typedef struct {
      logic       rdy;
      logic       zr;
      logic [5:0] op;
      logic [5:0] fc;
      outv_t      exp;
      string      tag;
   } cyc_t;

   typedef enum {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_t;

   outv_t      obs;
   cyc_t       q[$];
   logic [5:0] cur_op, cur_fc;
   int         n_vec = 0;
   int         n_bad = 0;

   assign obs = {pc_write, ir_write, reg_write, reg_dst, wd_sel, alu_src_b, alu_op,
                 pc_src, mem_req, mem_we, mem_addr_sel, illegal, mem_err, retire};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fc);
      case (op)
         6'b000000: begin
            if (fc == 6'b100001) return K_ADDU;
            if (fc == 6'b100011) return K_SUBU;
            if (fc == 6'b001000) return K_JR;
            return K_ILL;
         end
         6'b001101: return K_ORI;
         6'b001111: return K_LUI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rdy, input logic zr, input outv_t v, input string tag);
      cyc_t c;
      c.rdy = rdy; c.zr = zr; c.op = cur_op; c.fc = cur_fc; c.exp = v; c.tag = tag;
      q.push_back(c);
   endtask

   // One memory access of latency w: w unanswered cycles then completion,
   // or T unanswered cycles then the expiry cycle if w exceeds T.
   task automatic add_access(input int unsigned w, input outv_t base, input outv_t done,
                             input string tag, output bit ok);
      outv_t v;
      for (int unsigned i = 0; i < w && i < T; i++) push(1'b0, rnd(), base, {tag, "/wait"});
      if (w > T) begin
         v = base; v.mem_err = 1'b1;
         push(1'b0, rnd(), v, {tag, "/timeout"});
         ok = 1'b0;
      end else begin
         push(1'b1, rnd(), done, {tag, "/done"});
         ok = 1'b1;
      end
   endtask

   task automatic build_instr(input logic [5:0] op, input logic [5:0] fc, input int unsigned wf,
                              input int unsigned wm, input logic zr);
      outv_t v, d;
      bit ok;
      int unsigned w;
      kind_t k;
      string nm;
      cur_op = op; cur_fc = fc;
      k = classify(op, fc);
      nm = k.name();
      w = wf;
      do begin
         v = '0; v.mem_req = 1'b1;
         d = v; d.ir_write = 1'b1; d.pc_write = 1'b1;
         add_access(w, v, d, {nm, "/fetch"}, ok);
         w = $urandom_range(0, T);
      end while (!ok);
      v = '0; v.illegal = (k == K_ILL);
      push(rnd(), rnd(), v, {nm, "/decode"});
      v = '0;
      case (k)
         K_ADDU, K_SUBU, K_ORI: begin
            if (k == K_ORI) begin v.alu_src_b = 2'd1; v.alu_op = 2'd2; end
            else v.alu_op = (k == K_SUBU) ? 2'd1 : 2'd0;
            push(rnd(), rnd(), v, {nm, "/exe"});
            v.reg_write = 1'b1; v.retire = 1'b1;
            v.reg_dst = (k == K_ORI) ? 2'd0 : 2'd1;
            push(rnd(), rnd(), v, {nm, "/wb"});
         end
         K_LUI: begin
            v.reg_write = 1'b1; v.wd_sel = 2'd3; v.retire = 1'b1;
            push(rnd(), rnd(), v, {nm, "/wb"});
         end
         K_LW, K_SW: begin
            v.alu_src_b = 2'd2;
            push(rnd(), rnd(), v, {nm, "/addr"});
            v.mem_req = 1'b1; v.mem_addr_sel = 1'b1; v.mem_we = (k == K_SW);
            d = v; d.retire = (k == K_SW);
            add_access(wm, v, d, {nm, "/mem"}, ok);
            if (ok && k == K_LW) begin
               v = '0; v.reg_write = 1'b1; v.wd_sel = 2'd1; v.retire = 1'b1;
               push(rnd(), rnd(), v, {nm, "/wb"});
            end
         end
         K_BEQ: begin
            v.alu_op = 2'd1; v.pc_src = 2'd1; v.pc_write = zr; v.retire = 1'b1;
            push(rnd(), zr, v, {nm, "/br"});
         end
         K_J, K_JAL: begin
            v.pc_write = 1'b1; v.pc_src = 2'd2; v.retire = 1'b1;
            if (k == K_JAL) begin v.reg_write = 1'b1; v.reg_dst = 2'd2; v.wd_sel = 2'd2; end
            push(rnd(), rnd(), v, {nm, "/jump"});
         end
         K_JR: begin
            v.pc_write = 1'b1; v.pc_src = 2'd3; v.retire = 1'b1;
            push(rnd(), rnd(), v, {nm, "/jr"});
         end
         default: ;
      endcase
   endtask

   // Replay up to limit queued cycles: drive at negedge, sample 1 ns later.
   task automatic run_q(input int unsigned limit);
      cyc_t c;
      for (int unsigned n = 0; n < limit && q.size() > 0; n++) begin
         @(negedge clk);
         c = q.pop_front();
         reset = 1'b1; mem_ready = c.rdy; zero = c.zr; opcode = c.op; funct = c.fc;
         #1;
         chk(c.tag, 32'(obs), 32'(c.exp));
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         reset = 1'b0; mem_ready = 1'b1; zero = 1'b1;
         opcode = 6'($urandom); funct = 6'($urandom);
         #1;
         chk("reset_hold", 32'({state_o, obs}), 32'd0);
      end
   endtask

   logic [5:0] ops [10] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                            6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
   logic [5:0] fcs [10] = '{6'b100001, 6'b100011, 6'b001000, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

   initial begin
      int unsigned idx;
      logic [5:0]  rop, rfc;
      reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
      do_reset();

      build_instr(6'b000000, 6'b100001, 0, 0, 1'b0);   // addu, zero-wait
      build_instr(6'b100011, 6'b000000, 0, 3, 1'b0);   // lw, 3 wait cycles
      build_instr(6'b000100, 6'b000000, 0, 0, 1'b0);   // beq not taken
      build_instr(6'b000100, 6'b000000, 0, 0, 1'b1);   // beq taken
      build_instr(6'b000011, 6'b000000, 0, 0, 1'b0);   // jal
      build_instr(6'b111111, 6'b101010, 0, 0, 1'b0);   // unsupported
      build_instr(6'b001101, 6'b000000, T + 3, 0, 1'b0); // fetch timeout, retry
      build_instr(6'b001111, 6'b000000, T, 0, 1'b0);   // ready on expiry cycle
      build_instr(6'b100011, 6'b000000, 0, T + 2, 1'b0); // load timeout
      build_instr(6'b101011, 6'b000000, 0, T, 1'b0);   // store on expiry cycle
      build_instr(6'b101011, 6'b000000, 1, 0, 1'b0);
      build_instr(6'b000000, 6'b100011, 0, 0, 1'b0);   // subu
      build_instr(6'b000000, 6'b001000, 0, 0, 1'b0);   // jr
      build_instr(6'b000010, 6'b000000, 2, 0, 1'b0);   // j
      build_instr(6'b000000, 6'b000000, 0, 0, 1'b0);   // R-type, bad funct
      run_q(32'hFFFF_FFFF);

      // Reset landing in the middle of a load's memory wait.
      build_instr(6'b100011, 6'b000000, 0, 3, 1'b0);
      run_q(4);
      #3 reset = 1'b0;
      #1 chk("reset_mid", 32'({state_o, obs}), 32'd0);
      q.delete();
      do_reset();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            rop = 6'($urandom); rfc = 6'($urandom);
         end else begin
            idx = $urandom_range(0, 9);
            rop = ops[idx]; rfc = fcs[idx];
         end
         build_instr(rop, rfc, $urandom_range(0, T + 2), $urandom_range(0, T + 2), rnd());
         run_q(32'hFFFF_FFFF);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
